// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write bypass,
// hardwired zero register and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [AW-1:0]            alloc_addr_i,
  input  logic                     flush_i,
  output logic [DEPTH-1:0]         busy_vec_o
);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Later ports are applied last, so the highest index wins on collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] &&
            !(ZERO_REG != 0 && wr_addr_i[j*AW +: AW] == '0)) begin
          regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Alloc is applied after writeback clears so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j]) begin
          busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en_i) begin
        busy_d[alloc_addr_i] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            is_zero;

    assign addr    = rd_addr_i[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

    always_comb begin
      data = regs[addr];
      if (BYPASS != 0 && !rst_i) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == addr) begin
            data = wr_data_i[j*XLEN +: XLEN];
          end
        end
      end
      if (is_zero) begin
        data = '0;
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data;
    assign rd_busy_o[k]              = busy_q[addr] && !is_zero;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass on/off) sharing stimulus,
// checked against an array-based reference model.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NRD*AW-1:0]     rd_addr_i;
  logic [NRD*XLEN-1:0]   rd_data_bp;
  logic [NRD*XLEN-1:0]   rd_data_nb;
  logic [NRD-1:0]        rd_busy_bp;
  logic [NRD-1:0]        rd_busy_nb;
  logic [NWR-1:0]        wr_en_i;
  logic [NWR*AW-1:0]     wr_addr_i;
  logic [NWR*XLEN-1:0]   wr_data_i;
  logic                  alloc_en_i;
  logic [AW-1:0]         alloc_addr_i;
  logic                  flush_i;
  logic [DEPTH-1:0]      busy_bp;
  logic [DEPTH-1:0]      busy_nb;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0]  mem_m [DEPTH];
  logic [DEPTH-1:0] busy_m;

  reg_file_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR),
    .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_bp), .rd_busy_o(rd_busy_bp),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
    .flush_i(flush_i), .busy_vec_o(busy_bp)
  );

  reg_file_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR),
    .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
    .flush_i(flush_i), .busy_vec_o(busy_nb)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] a,
                                               input bit bp);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = mem_m[a];
    if (bp) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == a) begin
          v = wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
    return v;
  endfunction

  task automatic ref_edge();
    logic [AW-1:0] wa;
    if (rst_i) begin
      for (int r = 0; r < DEPTH; r++) mem_m[r] = '0;
      busy_m = '0;
      return;
    end
    for (int j = 0; j < NWR; j++) begin
      wa = wr_addr_i[j*AW +: AW];
      if (wr_en_i[j] && wa != 0) mem_m[wa] = wr_data_i[j*XLEN +: XLEN];
    end
    if (flush_i) begin
      busy_m = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j]) busy_m[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
      if (alloc_en_i) busy_m[alloc_addr_i] = 1'b1;
    end
    busy_m[0] = 1'b0;
  endtask

  task automatic check_reads();
    logic [AW-1:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr_i[k*AW +: AW];
      check($sformatf("rd_bp%0d@%0d", k, a),
            64'(rd_data_bp[k*XLEN +: XLEN]), 64'(ref_read(a, 1'b1)));
      check($sformatf("rd_nb%0d@%0d", k, a),
            64'(rd_data_nb[k*XLEN +: XLEN]), 64'(ref_read(a, 1'b0)));
      check($sformatf("rbusy%0d@%0d", k, a),
            64'(rd_busy_bp[k]), 64'(a != 0 && busy_m[a]));
    end
  endtask

  task automatic cycle();
    #1;
    if (!rst_i) check_reads();
    @(posedge clk_i);
    ref_edge();
    #1;
    check("busy_vec", 64'(busy_bp), 64'(busy_m));
    check("busy_vec_nb", 64'(busy_nb), 64'(busy_m));
  endtask

  task automatic idle();
    wr_en_i      = '0;
    wr_addr_i    = '0;
    wr_data_i    = '0;
    alloc_en_i   = 1'b0;
    alloc_addr_i = '0;
    flush_i      = 1'b0;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a,
                        input logic [XLEN-1:0] d);
    wr_en_i[j]               = 1'b1;
    wr_addr_i[j*AW +: AW]    = a;
    wr_data_i[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr_i = {a1, a0};
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      #1;
      check_reads();
    end
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    idle();
    alloc_en_i   = 1'b1;
    alloc_addr_i = a;
    cycle();
  endtask

  initial begin
    rst_i = 1'b1;
    rd_addr_i = '0;
    idle();
    for (int r = 0; r < DEPTH; r++) mem_m[r] = 'x;
    busy_m = 'x;
    cycle();
    cycle();
    rst_i = 1'b0;

    // Reset state on every address and port
    sweep_reads();
    check("p1_busy0", 64'(busy_bp), 64'd0);

    // Basic write and zero-register drop
    idle(); set_wr(0, 5, 32'hDEADBEEF); cycle();
    idle(); set_rd(5, 5); #1;
    check("p2_rd0", 64'(rd_data_bp[31:0]), 64'hDEADBEEF);
    check("p2_rd1", 64'(rd_data_bp[63:32]), 64'hDEADBEEF);
    set_wr(0, 0, 32'h1234); cycle();
    idle(); set_rd(0, 0); #1;
    check("p2_zero", 64'(rd_data_bp[31:0]), 64'd0);

    // Same-cycle bypass versus registered read
    set_wr(0, 7, 32'hA5A5A5A5); set_rd(7, 7); #1;
    check("p3_bp", 64'(rd_data_bp[31:0]), 64'hA5A5A5A5);
    check("p3_nb", 64'(rd_data_nb[31:0]), 64'd0);
    cycle();
    idle(); #1;
    check("p3_nb_next", 64'(rd_data_nb[31:0]), 64'hA5A5A5A5);

    // Colliding writes: port 1 wins
    set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(3, 3); #1;
    check("p4_bp", 64'(rd_data_bp[63:32]), 64'h22);
    cycle();
    idle(); #1;
    check("p4_store", 64'(rd_data_nb[31:0]), 64'h22);

    // Scoreboard alloc / writeback interaction
    alloc(9);
    idle(); set_rd(9, 1); #1;
    check("p5_vec9", 64'(busy_bp[9]), 64'd1);
    check("p5_rbusy9", 64'(rd_busy_bp[0]), 64'd1);
    alloc_en_i = 1'b1; alloc_addr_i = 9; set_wr(0, 9, 32'h99); cycle();
    check("p5_alloc_wins", 64'(busy_bp[9]), 64'd1);
    idle(); set_wr(1, 9, 32'h98); cycle();
    check("p5_wb_clear", 64'(busy_bp[9]), 64'd0);
    alloc(0);
    check("p5_zero_busy", 64'(busy_bp[0]), 64'd0);

    // Flush beats alloc; data untouched
    alloc(2); alloc(4); alloc(6);
    check("p6_allocd", 64'(busy_bp), 64'h54);
    idle(); flush_i = 1'b1; alloc_en_i = 1'b1; alloc_addr_i = 8; cycle();
    check("p6_flush", 64'(busy_bp), 64'd0);
    idle(); sweep_reads();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      rst_i = ($urandom_range(0, 79) == 0);
      for (int j = 0; j < NWR; j++) begin
        if ($urandom_range(0, 2) != 0) begin
          set_wr(j, AW'($urandom_range(0, n[0] ? 7 : DEPTH - 1)), $urandom);
        end
      end
      alloc_en_i   = ($urandom_range(0, 1) == 1);
      alloc_addr_i = AW'($urandom_range(0, n[1] ? 7 : DEPTH - 1));
      flush_i      = ($urandom_range(0, 15) == 0);
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, DEPTH - 1)));
      cycle();
    end
    rst_i = 1'b0;

    // Reset overrides a concurrent write
    idle(); sweep_reads();
    rst_i = 1'b1; set_wr(0, 5, 32'hCAFEF00D); alloc_en_i = 1'b1;
    alloc_addr_i = 5; cycle();
    rst_i = 1'b0; idle();
    check("rst_busy", 64'(busy_bp), 64'd0);
    sweep_reads();
    set_rd(5, 5); #1;
    check("rst_wr_ignored", 64'(rd_data_nb[31:0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
